axis_tlast_check: RTL and testbench

//  Receive-side counterpart of the TLAST inserter: consumes a framed AXI4-Stream, checks each packet

---
 rtl/axis_tlast_check_pkg.sv | 22 ++
 rtl/axis_tlast_check_if.sv | 13 +
 rtl/axis_tlast_check.sv | 87 ++++++++
 tb/tb_axis_tlast_check.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_tlast_check_pkg.sv
// rtl/axis_tlast_check_pkg.sv - shared state encoding and counter/keep helpers for the TLAST checker
package axis_tlast_check_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = {64{1'b1}} >> (64 - width);
    return (val == max_val) ? val : val + 64'd1;
  endfunction

  function automatic logic keep_all_ones(input logic [63:0] keep, input int width);
    for (int i = 0; i < 64; i++) begin
      if (i < width && !keep[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/axis_tlast_check_if.sv
// rtl/axis_tlast_check_if.sv - AXI4-Stream handshake bundle with master/slave views
interface axis_tlast_check_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_tlast_check.sv
// rtl/axis_tlast_check.sv - checks fixed-length framing, strips TLAST, counts packets and errors
module axis_tlast_check
  import axis_tlast_check_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int PKT_LENGTH  = 1024*1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  arm,
  input  logic [CNT_WIDTH-1:0]  npkts,
  axis_tlast_check_if.slave     s_axis,
  axis_tlast_check_if.master    m_axis,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_keep,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(PKT_LENGTH) + 1;
  localparam int KW = TDATA_WIDTH / 8;
  localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LENGTH - 1);

  logic [1:0]    state;
  logic          arm_d;
  logic [BW-1:0] beat_cnt;

  logic arm_rise, go, beat, at_end, boundary, is_short, is_long, final_pkt, keep_bad;

  assign arm_rise = arm & ~arm_d;
  // The arm cycle never moves data, so a restart cannot split a beat across two runs.
  assign go       = (state == ST_RUN) & ~arm_rise;

  assign s_axis.tready = go & m_axis.tready;
  assign m_axis.tvalid = go & s_axis.tvalid;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = 1'b0;

  assign beat      = s_axis.tvalid & s_axis.tready;
  assign at_end    = (beat_cnt == LAST_IDX);
  assign boundary  = beat & (s_axis.tlast | at_end);
  assign is_short  = beat & s_axis.tlast & ~at_end;
  assign is_long   = beat & ~s_axis.tlast & at_end;
  assign final_pkt = boundary & (npkts != '0) & (pkt_count == npkts - CNT_WIDTH'(1));
  assign keep_bad  = beat & ~keep_all_ones(64'(s_axis.tkeep), KW);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      arm_d     <= 1'b0;
      beat_cnt  <= '0;
      pkt_count <= '0;
      err_count <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_keep  <= 1'b0;
    end else begin
      arm_d <= arm;
      if (arm_rise) begin
        state     <= ST_RUN;
        beat_cnt  <= '0;
        pkt_count <= '0;
        err_count <= '0;
        err_short <= 1'b0;
        err_long  <= 1'b0;
        err_keep  <= 1'b0;
      end else if (state == ST_RUN) begin
        if (beat) beat_cnt <= boundary ? '0 : beat_cnt + BW'(1);
        if (boundary) pkt_count <= CNT_WIDTH'(sat_inc(64'(pkt_count), CNT_WIDTH));
        if (is_short | is_long) err_count <= CNT_WIDTH'(sat_inc(64'(err_count), CNT_WIDTH));
        if (is_short) err_short <= 1'b1;
        if (is_long)  err_long  <= 1'b1;
        if (keep_bad) err_keep  <= 1'b1;
        if (final_pkt) state <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_tlast_check.sv
// tb/tb_axis_tlast_check.sv - directed vector table plus multi-cycle sequences for axis_tlast_check
module tb_axis_tlast_check;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] npkts = '0;
  logic [31:0] pkt_count, err_count;
  logic        err_short, err_long, err_keep, busy, done;

  axis_tlast_check_if #(.TDATA_WIDTH(16)) s_if ();
  axis_tlast_check_if #(.TDATA_WIDTH(16)) m_if ();

  axis_tlast_check #(.TDATA_WIDTH(16), .PKT_LENGTH(4), .CNT_WIDTH(32)) dut (
    .aclk      (aclk),
    .resetn    (resetn),
    .arm       (arm),
    .npkts     (npkts),
    .s_axis    (s_if.slave),
    .m_axis    (m_if.master),
    .pkt_count (pkt_count),
    .err_count (err_count),
    .err_short (err_short),
    .err_long  (err_long),
    .err_keep  (err_keep),
    .busy      (busy),
    .done      (done)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        arm, tvalid, tlast, mready;
    logic [1:0]  tkeep;
    logic [15:0] tdata;
    logic        x_tready, x_mvalid, x_busy, x_done;
    int          x_pkt, x_err;
    logic        x_short, x_long, x_keep;
  } vec_t;

  vec_t vecs[12];

  task automatic settle();
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    #1;
  endtask

  task automatic arm_pulse();
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    arm = 1'b0;
    @(negedge aclk);
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
  endtask

  // Holds the beat until the DUT accepts it; m_axis_tready is randomised ~70%.
  task automatic send_beat(input logic [15:0] data, input logic last, input logic [1:0] keep);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge aclk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = data;
      s_if.tlast  = last;
      s_if.tkeep  = keep;
      m_if.tready = ($urandom_range(0, 9) < 7);
      #1;
      acc = s_if.tready;
      if (acc) begin
        check("fwd_valid", m_if.tvalid, 1'b1);
        check("fwd_data", m_if.tdata, data);
      end
      @(posedge aclk);
    end
    if (!acc) check("beat_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b1,2'b11,16'h1000, 1'b0,1'b0,1'b0,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b1,2'b11,16'h1001, 1'b0,1'b0,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b1,2'b11,16'h1002, 1'b1,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,2'b11,16'h1003, 1'b0,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,2'b11,16'h1004, 1'b1,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,2'b11,16'h1005, 1'b1,1'b0,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,2'b11,16'h1006, 1'b1,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,2'b11,16'h1007, 1'b1,1'b1,1'b1,1'b0, 1,0, 1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,2'b11,16'h1008, 1'b1,1'b1,1'b0,1'b1, 2,1, 1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,2'b11,16'h1009, 1'b0,1'b0,1'b0,1'b1, 2,1, 1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b1,2'b11,16'h100a, 1'b0,1'b0,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,2'b01,16'h100b, 1'b1,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b1};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = 2'b11; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    check("rst_tready", s_if.tready, 1'b0);
    check("rst_mvalid", m_if.tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pkt", pkt_count, 0);
    check("rst_err", err_count, 0);
    @(negedge aclk);
    resetn = 1'b1;

    // Table: gating, arm edge, boundary, short + final packet, rearm from DONE, tkeep
    npkts = 32'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      arm = vecs[i].arm;
      s_if.tvalid = vecs[i].tvalid;
      s_if.tlast  = vecs[i].tlast;
      s_if.tkeep  = vecs[i].tkeep;
      s_if.tdata  = vecs[i].tdata;
      m_if.tready = vecs[i].mready;
      #1;
      check($sformatf("v%0d_tready", i), s_if.tready, vecs[i].x_tready);
      check($sformatf("v%0d_mvalid", i), m_if.tvalid, vecs[i].x_mvalid);
      if (vecs[i].x_mvalid) check($sformatf("v%0d_mdata", i), m_if.tdata, vecs[i].tdata);
      @(posedge aclk);
      #1;
      check($sformatf("v%0d_busy", i), busy, vecs[i].x_busy);
      check($sformatf("v%0d_done", i), done, vecs[i].x_done);
      check($sformatf("v%0d_pkt", i), pkt_count, vecs[i].x_pkt);
      check($sformatf("v%0d_err", i), err_count, vecs[i].x_err);
      check($sformatf("v%0d_short", i), err_short, vecs[i].x_short);
      check($sformatf("v%0d_long", i), err_long, vecs[i].x_long);
      check($sformatf("v%0d_keep", i), err_keep, vecs[i].x_keep);
    end

    // Three clean packets, then DONE with upstream held off
    npkts = 32'd3;
    arm_pulse();
    for (int i = 0; i < 12; i++) send_beat(16'h2000 + 16'(i), (i % 4) == 3, 2'b11);
    @(negedge aclk);
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    #1;
    check("t1_done", done, 1'b1);
    check("t1_pkt", pkt_count, 3);
    check("t1_err", err_count, 0);
    check("t1_hold_tready", s_if.tready, 1'b0);
    check("t1_hold_mvalid", m_if.tvalid, 1'b0);

    // Short packet, then the next beat must start a fresh packet
    npkts = 32'd0;
    arm_pulse();
    for (int i = 0; i < 3; i++) send_beat(16'h3000 + 16'(i), i == 2, 2'b11);
    settle();
    check("t2_short", err_short, 1'b1);
    check("t2_err", err_count, 1);
    check("t2_pkt", pkt_count, 1);
    for (int i = 0; i < 4; i++) send_beat(16'h3100 + 16'(i), i == 3, 2'b11);
    settle();
    check("t2_realign_pkt", pkt_count, 2);
    check("t2_realign_err", err_count, 1);
    check("t2_busy", busy, 1'b1);

    // Missing TLAST: long error at beat 4, beats 5..8 form the next packet
    arm_pulse();
    for (int i = 0; i < 4; i++) send_beat(16'h4000 + 16'(i), 1'b0, 2'b11);
    settle();
    check("t3_long", err_long, 1'b1);
    check("t3_pkt", pkt_count, 1);
    check("t3_err", err_count, 1);
    for (int i = 4; i < 8; i++) send_beat(16'h4000 + 16'(i), i == 7, 2'b11);
    settle();
    check("t3_pkt2", pkt_count, 2);
    check("t3_err2", err_count, 1);
    check("t3_no_short", err_short, 1'b0);

    // Reset mid-packet
    arm_pulse();
    for (int i = 0; i < 2; i++) send_beat(16'h5000 + 16'(i), 1'b0, 2'b01);
    @(negedge aclk);
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    resetn = 1'b0;
    #1;
    check("t6_tready", s_if.tready, 1'b0);
    check("t6_mvalid", m_if.tvalid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_keep", err_keep, 1'b0);
    check("t6_pkt", pkt_count, 0);
    @(negedge aclk);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    check("t6_idle_tready", s_if.tready, 1'b0);
    check("t6_idle_busy", busy, 1'b0);
    arm_pulse();
    for (int i = 0; i < 4; i++) send_beat(16'h6000 + 16'(i), i == 3, 2'b11);
    settle();
    check("t6_pkt_after", pkt_count, 1);
    check("t6_err_after", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
